// File: rtl/rca_seq_pkg.sv
// Shared constants and types for the nibble-serial add/subtract sequencer.
package rca_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } rca_seq_state_t;

   // Nibble counter width; a single-nibble build still needs one bit.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/fulladd.sv
// 4-bit ripple-carry adder built from a chain of one-bit full adders.
module fulladd (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic       c_out,
   output logic [3:0] sum
);

   logic [4:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = c_in;
      for (int i = 0; i < 4; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      c_out = carry[4];
   end

endmodule

// File: rtl/rca_seq.sv
// Wide add/subtract sequenced through one shared 4-bit fulladd, one nibble
// per cycle LSB first, with the carry held in a register between nibbles.
module rca_seq
   import rca_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
   input  logic                      sub,
   input  logic                      c_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] result,
   output logic                      c_out,
   output logic                      ovf
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   rca_seq_state_t      state;
   logic [IDX_W-1:0]    idx;
   logic                carry;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic [W-1:0]        result_q;
   logic                c_out_q;
   logic                ovf_q;

   logic [NIBBLE_W-1:0] fa_a;
   logic [NIBBLE_W-1:0] fa_b;
   logic [NIBBLE_W-1:0] fa_sum;
   logic                fa_c_out;
   logic                accept;
   logic                last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (idx == IDX_LAST);

   assign fa_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
   assign fa_b = b_q[NIBBLE_W*idx +: NIBBLE_W];

   fulladd u_fulladd (
      .a     (fa_a),
      .b     (fa_b),
      .c_in  (carry),
      .c_out (fa_c_out),
      .sum   (fa_sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // Subtraction is A + ~B + 1, so B is inverted once on entry.
                  a_q   <= op_a;
                  b_q   <= op_b ^ {W{sub}};
                  carry <= sub ? 1'b1 : c_in;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               result_q[NIBBLE_W*idx +: NIBBLE_W] <= fa_sum;
               carry <= fa_c_out;
               if (last) begin
                  c_out_q <= fa_c_out;
                  ovf_q   <= (a_q[W-1] == b_q[W-1]) && (fa_sum[NIBBLE_W-1] != a_q[W-1]);
                  idx     <= '0;
                  state   <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   assign result = result_q;
   assign c_out  = c_out_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_rca_seq.sv
// Scoreboard bench for rca_seq (NIBBLES=4): reference results are queued at accept
// and compared when out_valid appears.
module tb_rca_seq;

   typedef struct packed {
      logic [15:0] res;
      logic        co;
      logic        ov;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        sub;
   logic        c_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        c_out;
   logic        ovf;

   exp_t exp_q[$];
   exp_t cur;
   int   tests_run;
   int   tests_failed;

   rca_seq #(.NIBBLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic ci);
      logic [15:0] bb;
      logic [16:0] full;
      exp_t e;
      bb   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : ci)};
      e.res = full[15:0];
      e.co  = full[16];
      e.ov  = (a[15] == bb[15]) && (full[15] != a[15]);
      return e;
   endfunction

   // Present a request, wait (bounded) for in_ready, and queue the reference at the accept edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci, input logic track);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      op_a = a;
      op_b = b;
      sub  = s;
      c_in = ci;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      if (track) exp_q.push_back(model(a, b, s, ci));
      #1;
      in_valid = 1'b0;
   endtask

   // Called just after the accept edge: expects out_valid exactly 4 edges later.
   task automatic wait_result(input string tag);
      int lat;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) break;
      end
      chk({tag, "_latency"}, lat, 4);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
         cur = '0;
      end else begin
         cur = exp_q.pop_front();
      end
      chk({tag, "_result"}, result, cur.res);
      chk({tag, "_c_out"}, c_out, cur.co);
      chk({tag, "_ovf"}, ovf, cur.ov);
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_vld_drop"}, out_valid, 0);
      chk({tag, "_rdy_back"}, in_ready, 1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      sub       = 1'b0;
      c_in      = 1'b0;
      out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_c_out", c_out, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;

      send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
      wait_result("add_basic");
      chk("add_basic_exp", cur.res, 16'h2233);
      release_result("add_basic");

      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      wait_result("add_ripple");
      chk("add_ripple_co", {cur.res, 15'd0, cur.co}, {16'h0000, 16'h0001});
      release_result("add_ripple");

      send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
      wait_result("sub_ovf");
      release_result("sub_ovf");

      send(16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1);
      wait_result("add_cin_ovf");
      release_result("add_cin_ovf");

      send(16'h5A5A, 16'hC3C3, 1'b1, 1'b1, 1'b1);
      wait_result("sub_mix");
      release_result("sub_mix");

      // Backpressure: result must hold while in_valid/operands wiggle.
      send(16'h4321, 16'h1111, 1'b0, 1'b1, 1'b1);
      wait_result("bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = i[0];
         op_a = 16'($urandom);
         op_b = 16'($urandom);
         sub  = i[1];
         c_in = ~i[0];
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_result", result, cur.res);
         chk("bp_c_out", c_out, cur.co);
         chk("bp_ovf", ovf, cur.ov);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      op_a      = 16'h0101;
      op_b      = 16'h0202;
      sub       = 1'b0;
      c_in      = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_handoff_rdy", in_ready, 1);
      chk("bp_handoff_vld", out_valid, 0);
      @(posedge clk);
      exp_q.push_back(model(16'h0101, 16'h0202, 1'b0, 1'b0));
      #1;
      in_valid = 1'b0;
      chk("bp_new_accept", in_ready, 0);
      wait_result("bp_next");
      chk("bp_next_exp", cur.res, 16'h0303);
      release_result("bp_next");

      // Reset during the second RUN cycle discards the operation.
      send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_c_out", c_out, 0);
      send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
      wait_result("post_rst");
      chk("post_rst_exp", cur.res, 16'h0002);
      release_result("post_rst");

      for (int i = 0; i < 6; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         send(ra, rb, i[0], i[1], 1'b1);
         wait_result("rand");
         release_result("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0x0 expected 0x1");
      $fatal(1, "timeout");
   end

endmodule
